mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/arb_rr2.sv | 32 +++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_MEM_LAT = 4;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Bit positions in the 2-bit request/grant vectors follow this encoding.
  typedef enum logic {
    SIDE_IC = 1'b0,
    SIDE_DC = 1'b1
  } side_t;

  function automatic logic [CNT_W-1:0] lat_load(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker; bit 0 is the instruction side, bit 1 the data side.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic [1:0] o_gnt
);

  // Side that wins the next tie; after reset the data side has priority.
  side_t r_prio;

  always_comb begin
    o_gnt = 2'b00;
    if (i_req == 2'b11) begin
      o_gnt = (r_prio == SIDE_DC) ? 2'b10 : 2'b01;
    end else begin
      o_gnt = i_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= SIDE_DC;
    end else if (i_update && (o_gnt != 2'b00)) begin
      r_prio <= o_gnt[1] ? SIDE_IC : SIDE_DC;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between an instruction-refill side and a
// data side (read refill or write-through) using a three-state FSM.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int MEM_LAT = DEF_MEM_LAT
)
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [WIDTH-1:0]  dc_wdata,
  output logic              ic_gnt,
  output logic              dc_gnt,
  output logic              ic_done,
  output logic              dc_done,
  output logic [WIDTH-1:0]  rdata,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  output state_t            o_dbg_state
);

  // Handshake: a side raises req and holds it (with stable addr/we/wdata) until
  // its done pulse. Only a req seen in IDLE starts an access; gnt pulses in the
  // first ACCESS cycle, done in the single DONE cycle. Dropping req mid-access
  // does not cancel it.

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  side_t             r_side;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [WIDTH-1:0]  r_mem_wdata;
  logic [WIDTH-1:0]  r_rdata;
  logic              r_ic_gnt;
  logic              r_dc_gnt;
  logic              r_ic_done;
  logic              r_dc_done;

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_take;
  side_t             w_win;

  assign w_req  = {dc_req, ic_req};
  assign w_take = (r_state == ST_IDLE) && (w_req != 2'b00);
  assign w_win  = w_gnt[1] ? SIDE_DC : SIDE_IC;

  arb_rr2 u_rr (
    .clk      (CLK),
    .rst_n    (RST),
    .i_req    (w_req),
    .i_update (w_take),
    .o_gnt    (w_gnt)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_side      <= SIDE_IC;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_ic_gnt    <= 1'b0;
      r_dc_gnt    <= 1'b0;
      r_ic_done   <= 1'b0;
      r_dc_done   <= 1'b0;
    end else begin
      r_ic_gnt  <= 1'b0;
      r_dc_gnt  <= 1'b0;
      r_ic_done <= 1'b0;
      r_dc_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_state  <= ST_ACCESS;
            r_cnt    <= lat_load(MEM_LAT);
            r_side   <= w_win;
            r_mem_en <= 1'b1;
            if (w_win == SIDE_DC) begin
              r_dc_gnt    <= 1'b1;
              r_mem_we    <= dc_we;
              r_mem_addr  <= dc_addr;
              r_mem_wdata <= dc_wdata;
            end else begin
              r_ic_gnt   <= 1'b1;
              r_mem_we   <= 1'b0;
              r_mem_addr <= ic_addr;
            end
          end
        end
        ST_ACCESS: begin
          if (r_cnt == '0) begin
            r_state  <= ST_DONE;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            // mem_rdata is valid in this last enabled cycle.
            if (!r_mem_we) begin
              r_rdata <= mem_rdata;
            end
            if (r_side == SIDE_DC) begin
              r_dc_done <= 1'b1;
            end else begin
              r_ic_done <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign stall       = (ic_req & ~r_ic_done) | (dc_req & ~r_dc_done);
  assign ic_gnt      = r_ic_gnt;
  assign dc_gnt      = r_dc_gnt;
  assign ic_done     = r_ic_done;
  assign dc_done     = r_dc_done;
  assign rdata       = r_rdata;
  assign mem_en      = r_mem_en;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a MEM_LAT=4 instance driven by a vector table and
// hand sequences, plus a MEM_LAT=1 instance for the short-latency corner.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int LAT = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;

  logic        ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0;
  logic [9:0]  ic_addr = '0, dc_addr = '0;
  logic [31:0] dc_wdata = '0;
  logic        ic_gnt, dc_gnt, ic_done, dc_done, stall, mem_en, mem_we;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;
  state_t      dbg_state;

  logic        ic_req_1 = 1'b0, dc_req_1 = 1'b0, dc_we_1 = 1'b0;
  logic [9:0]  ic_addr_1 = '0, dc_addr_1 = '0;
  logic [31:0] dc_wdata_1 = '0;
  logic        ic_gnt_1, dc_gnt_1, ic_done_1, dc_done_1, stall_1, mem_en_1, mem_we_1;
  logic [31:0] rdata_1, mem_wdata_1, mem_rdata_1;
  logic [9:0]  mem_addr_1;
  state_t      dbg_state_1;

  int          n_vec = 0;
  int          n_err = 0;
  int          excl_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem [0:1023];

  typedef struct {
    logic        is_dc;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t tbl[12];

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.WIDTH(32), .ADDR_W(10), .MEM_LAT(LAT)) u_dut (
    .CLK(CLK), .RST(RST),
    .ic_req(ic_req), .ic_addr(ic_addr),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .ic_gnt(ic_gnt), .dc_gnt(dc_gnt), .ic_done(ic_done), .dc_done(dc_done),
    .rdata(rdata), .stall(stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .o_dbg_state(dbg_state)
  );

  mem_port_arbiter #(.WIDTH(32), .ADDR_W(10), .MEM_LAT(1)) u_dut1 (
    .CLK(CLK), .RST(RST),
    .ic_req(ic_req_1), .ic_addr(ic_addr_1),
    .dc_req(dc_req_1), .dc_we(dc_we_1), .dc_addr(dc_addr_1), .dc_wdata(dc_wdata_1),
    .ic_gnt(ic_gnt_1), .dc_gnt(dc_gnt_1), .ic_done(ic_done_1), .dc_done(dc_done_1),
    .rdata(rdata_1), .stall(stall_1),
    .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
    .mem_rdata(mem_rdata_1), .o_dbg_state(dbg_state_1)
  );

  // Memory environment: combinational read, write on enabled write cycles.
  assign mem_rdata   = mem[mem_addr];
  assign mem_rdata_1 = 32'h0A11_0000 | {22'h0, mem_addr_1};

  always @(posedge CLK) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
  end

  always @(negedge CLK) begin
    if (RST) begin
      if ((ic_gnt && dc_gnt) || (ic_done && dc_done) || (mem_we && !mem_en)) excl_bad++;
      if ((ic_gnt_1 && dc_gnt_1) || (ic_done_1 && dc_done_1) || (mem_we_1 && !mem_en_1)) excl_bad++;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pop_chk(input string nm, input logic [31:0] act);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: completion with rdata %0h but no expected entry", nm, act);
    end else begin
      e = exp_q.pop_front();
      chk(nm, act, e);
    end
  endtask

  // Single-side transaction on the MEM_LAT=4 instance, starting in IDLE.
  task automatic run_one(input string nm, input logic is_dc, input logic we,
                         input logic [9:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp, input logic hold);
    int gc, dcy, en_n, bad, other;
    gc = -1; dcy = -1; en_n = 0; bad = 0; other = 0;
    exp_q.push_back(exp);
    if (is_dc) begin
      dc_req = 1'b1; dc_we = we; dc_addr = addr; dc_wdata = wdata;
    end else begin
      ic_req = 1'b1; ic_addr = addr;
    end
    #1;
    chk({nm, " stall_c0"}, stall, 1);
    for (int c = 1; c <= LAT + 8 && dcy < 0; c++) begin
      tick();
      if ((is_dc ? dc_gnt : ic_gnt) && gc < 0) gc = c;
      if (is_dc ? (ic_gnt || ic_done) : (dc_gnt || dc_done)) other++;
      if (mem_en) begin
        en_n++;
        if (mem_addr !== addr || mem_we !== we || (we && mem_wdata !== wdata)) bad++;
      end
      if (is_dc ? dc_done : ic_done) begin
        dcy = c;
        pop_chk({nm, " rdata"}, rdata);
        chk({nm, " stall_done"}, stall, 0);
      end
    end
    if (!hold) begin
      if (is_dc) dc_req = 1'b0; else ic_req = 1'b0;
    end
    tick();
    chk({nm, " idle_after_done"}, {dbg_state, mem_en, ic_gnt, dc_gnt}, {ST_IDLE, 3'b000});
    chk({nm, " gnt_cycle"}, gc, 1);
    chk({nm, " done_cycle"}, dcy, LAT + 1);
    chk({nm, " mem_en_cycles"}, en_n, LAT);
    chk({nm, " mem_bus_bad"}, bad, 0);
    chk({nm, " other_side"}, other, 0);
  endtask

  // Both sides request together; data side must be served first, then instruction.
  task automatic tie_run(input string nm, input logic [9:0] ia, input logic [9:0] da);
    int dg, dd, ig, id;
    dg = -1; dd = -1; ig = -1; id = -1;
    exp_q.push_back(32'hC0DE_0000 | {22'h0, da});
    exp_q.push_back(32'hC0DE_0000 | {22'h0, ia});
    ic_req = 1'b1; ic_addr = ia;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = da;
    for (int c = 1; c <= 3 * LAT + 10 && (dd < 0 || id < 0); c++) begin
      tick();
      if (dc_gnt && dg < 0) dg = c;
      if (ic_gnt && ig < 0) ig = c;
      if (dc_done && dd < 0) begin
        dd = c;
        pop_chk({nm, " dc_rdata"}, rdata);
        dc_req = 1'b0;
      end
      if (ic_done && id < 0) begin
        id = c;
        pop_chk({nm, " ic_rdata"}, rdata);
        ic_req = 1'b0;
      end
    end
    ic_req = 1'b0;
    dc_req = 1'b0;
    tick();
    chk({nm, " dc_gnt_cycle"}, dg, 1);
    chk({nm, " dc_done_cycle"}, dd, LAT + 1);
    chk({nm, " ic_gnt_cycle"}, ig, LAT + 3);
    chk({nm, " ic_done_cycle"}, id, 2 * LAT + 3);
  endtask

  initial begin
    int n_done;
    logic [9:0] ra;

    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[10'h010] = 32'hDEADBEEF;

    tbl[0] = '{1'b1, 1'b0, 10'h010, 32'h0,         32'hDEADBEEF};
    tbl[1] = '{1'b1, 1'b1, 10'h3FF, 32'h12345678,  32'hDEADBEEF};
    tbl[2] = '{1'b0, 1'b0, 10'h3FF, 32'h0,         32'h12345678};
    tbl[3] = '{1'b0, 1'b0, 10'h000, 32'h0,         32'hC0DE0000};
    tbl[4] = '{1'b1, 1'b0, 10'h2AA, 32'h0,         32'hC0DE02AA};
    tbl[5] = '{1'b1, 1'b1, 10'h155, 32'hCAFEF00D,  32'hC0DE02AA};
    tbl[6] = '{1'b0, 1'b0, 10'h155, 32'h0,         32'hCAFEF00D};
    tbl[7] = '{1'b1, 1'b0, 10'h0FF, 32'h0,         32'hC0DE00FF};
    for (int i = 8; i < 12; i++) begin
      ra = 10'($urandom_range(32'h020, 32'h0F0));
      tbl[i] = '{1'($urandom_range(0, 1)), 1'b0, ra, 32'h0, 32'hC0DE0000 | {22'h0, ra}};
    end

    // Reset state.
    tick();
    chk("reset outputs",
        {ic_gnt, dc_gnt, ic_done, dc_done, mem_en, mem_we, stall},
        7'b0);
    chk("reset bus", {mem_addr, mem_wdata, rdata}, 74'h0);
    chk("reset state", dbg_state, ST_IDLE);
    RST = 1'b1;

    // Round-robin: reset pointer favours data side, and so does the next tie.
    tie_run("tie1", 10'h080, 10'h040);
    tie_run("tie2", 10'h081, 10'h041);

    // Reset in cycle 2 of an instruction access aborts it.
    ic_req = 1'b1; ic_addr = 10'h0C3;
    tick();
    tick();
    chk("rst_mid pre mem_en", mem_en, 1);
    RST = 1'b0;
    #1;
    chk("rst_mid mem_en async", {mem_en, mem_we, ic_gnt, ic_done}, 4'b0);
    chk("rst_mid state", dbg_state, ST_IDLE);
    chk("rst_mid rdata", rdata, 0);
    chk("rst_mid stall comb", stall, 1);
    ic_req = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    n_done = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (ic_done || dc_done || mem_en) n_done++;
    end
    chk("rst_mid no done", n_done, 0);

    // Table of single-side transactions.
    for (int i = 0; i < 12; i++) begin
      run_one($sformatf("vec%0d", i), tbl[i].is_dc, tbl[i].we, tbl[i].addr,
              tbl[i].wdata, tbl[i].exp_rdata, 1'b0);
    end

    // Request held across DONE: next access begins only from IDLE.
    run_one("hold_a", 1'b1, 1'b0, 10'h010, 32'h0, 32'hDEADBEEF, 1'b1);
    run_one("hold_b", 1'b1, 1'b0, 10'h3FF, 32'h0, 32'h12345678, 1'b0);

    // MEM_LAT=1 instance.
    exp_q.push_back(32'h0A11_0021);
    dc_req_1 = 1'b1; dc_we_1 = 1'b0; dc_addr_1 = 10'h021;
    #1;
    chk("lat1 c0 stall", stall_1, 1);
    tick();
    chk("lat1 c1", {dc_gnt_1, mem_en_1, stall_1, dc_done_1}, 4'b1110);
    tick();
    chk("lat1 c2", {dc_gnt_1, mem_en_1, stall_1, dc_done_1}, 4'b0001);
    if (dc_done_1) pop_chk("lat1 rdata", rdata_1);
    dc_req_1 = 1'b0;
    tick();
    chk("lat1 c3 state", dbg_state_1, ST_IDLE);

    chk("exclusivity", excl_bad, 0);
    chk("scoreboard empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
